// File: rtl/v_dreq_gen.sv
// v_dreq_gen: peripheral-side DMA request generator.
// Turns RX fill level / TX free space into burst requests toward the DMA
// request mux and counts the per-beat acks returned for each burst.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   ren_i / wen_i         direction enables
//   rlvl_i / wfree_i      RX entries available / TX entries free
//   rthr_i / wthr_i       burst length (0 -> 1, clamped to FIFO_DEPTH)
//   rreq_o / wreq_o       request levels toward the mux
//   rack_i / wack_i       one pulse per completed beat
//   rbusy_o / wbusy_o     direction FSM not idle
//   rrem_o / wrem_o       beats remaining in the current burst
//   err_o, clr_err_i      sticky stray-ack error and its clear

// One direction: IDLE -> REQ (counting acks) -> GAP -> IDLE.
module v_dreq_dir #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [LW-1:0] lvl_i,
    input  logic [LW-1:0] thr_i,
    input  logic          ack_i,
    output logic          req_o,
    output logic          busy_o,
    output logic [LW-1:0] rem_o,
    output logic          ackerr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nxt;
    logic [LW-1:0] r_rem;
    logic [LW-1:0] w_thr_eff;
    logic          w_go;

    always_comb begin
        w_thr_eff = thr_i;
        if (thr_i == '0)
            w_thr_eff = LW'(1);
        else if (thr_i > LW'(DEPTH))
            w_thr_eff = LW'(DEPTH);
    end

    assign w_go = en_i && (lvl_i >= w_thr_eff);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_nxt;
    end

    // Next-state logic
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_go) w_nxt = S_REQ;
            S_REQ:  if (ack_i && r_rem == LW'(1)) w_nxt = S_GAP;
            S_GAP:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Beat counter: loaded on burst start, forced to 0 outside REQ
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rem <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: r_rem <= w_go ? w_thr_eff : '0;
                S_REQ: begin
                    if (ack_i && r_rem != '0)
                        r_rem <= r_rem - LW'(1);
                end
                default: r_rem <= '0;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req_o    = (r_state == S_REQ);
        busy_o   = (r_state != S_IDLE);
        rem_o    = r_rem;
        // An ack is only legal while the request is visible
        ackerr_o = ack_i && (r_state != S_REQ);
    end

endmodule

module v_dreq_gen #(
    parameter int FIFO_DEPTH = 16,
    parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ren_i,
    input  logic          wen_i,
    input  logic [LW-1:0] rlvl_i,
    input  logic [LW-1:0] wfree_i,
    input  logic [LW-1:0] rthr_i,
    input  logic [LW-1:0] wthr_i,
    output logic          rreq_o,
    output logic          wreq_o,
    input  logic          rack_i,
    input  logic          wack_i,
    output logic          rbusy_o,
    output logic          wbusy_o,
    output logic [LW-1:0] rrem_o,
    output logic [LW-1:0] wrem_o,
    output logic          err_o,
    input  logic          clr_err_i
);

    logic w_rerr;
    logic w_werr;
    logic r_err;

    v_dreq_dir #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_rd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (ren_i),
        .lvl_i    (rlvl_i),
        .thr_i    (rthr_i),
        .ack_i    (rack_i),
        .req_o    (rreq_o),
        .busy_o   (rbusy_o),
        .rem_o    (rrem_o),
        .ackerr_o (w_rerr)
    );

    v_dreq_dir #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_wr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (wen_i),
        .lvl_i    (wfree_i),
        .thr_i    (wthr_i),
        .ack_i    (wack_i),
        .req_o    (wreq_o),
        .busy_o   (wbusy_o),
        .rem_o    (wrem_o),
        .ackerr_o (w_werr)
    );

    // Sticky error; a new stray ack beats a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_err <= 1'b0;
        else if (w_rerr || w_werr)
            r_err <= 1'b1;
        else if (clr_err_i)
            r_err <= 1'b0;
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_v_dreq_gen.sv
// Testbench for v_dreq_gen: directed scenarios plus random traffic,
// every cycle compared against a burst-level reference model.
module tb_v_dreq_gen;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ren = 1'b0;
    logic          wen = 1'b0;
    logic [LW-1:0] rlvl = '0;
    logic [LW-1:0] wfree = '0;
    logic [LW-1:0] rthr = '0;
    logic [LW-1:0] wthr = '0;
    logic          rack = 1'b0;
    logic          wack = 1'b0;
    logic          clr = 1'b0;
    logic          rreq, wreq, rbusy, wbusy, err;
    logic [LW-1:0] rrem, wrem;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: beats left in burst, cooldown cycles left, error flag
    int m_rl = 0, m_rg = 0, m_wl = 0, m_wg = 0;
    bit m_err = 0;

    v_dreq_gen #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .ren_i     (ren),
        .wen_i     (wen),
        .rlvl_i    (rlvl),
        .wfree_i   (wfree),
        .rthr_i    (rthr),
        .wthr_i    (wthr),
        .rreq_o    (rreq),
        .wreq_o    (wreq),
        .rack_i    (rack),
        .wack_i    (wack),
        .rbusy_o   (rbusy),
        .wbusy_o   (wbusy),
        .rrem_o    (rrem),
        .wrem_o    (wrem),
        .err_o     (err),
        .clr_err_i (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int t);
        if (t < 1) return 1;
        if (t > DEPTH) return DEPTH;
        return t;
    endfunction

    task automatic dir_upd(inout int left, inout int gap, input bit en,
                           input int lvl, input int thr, input bit ack,
                           output bit e);
        e = 0;
        if (left > 0) begin
            if (ack) begin
                left--;
                if (left == 0) gap = 1;
            end
        end else if (gap > 0) begin
            e = ack;
            gap = 0;
        end else begin
            e = ack;
            if (en && lvl >= eff(thr)) left = eff(thr);
        end
    endtask

    // One clock: model sees the same inputs the DUT samples, then compare.
    task automatic step();
        bit er, ew;
        @(posedge clk);
        if (rst) begin
            m_rl = 0; m_rg = 0; m_wl = 0; m_wg = 0; m_err = 0;
        end else begin
            dir_upd(m_rl, m_rg, ren, int'(rlvl), int'(rthr), rack, er);
            dir_upd(m_wl, m_wg, wen, int'(wfree), int'(wthr), wack, ew);
            if (er || ew) m_err = 1;
            else if (clr) m_err = 0;
        end
        #1;
        chk("rreq", int'(rreq), int'(m_rl > 0));
        chk("rbusy", int'(rbusy), int'(m_rl > 0 || m_rg > 0));
        chk("rrem", int'(rrem), m_rl);
        chk("wreq", int'(wreq), int'(m_wl > 0));
        chk("wbusy", int'(wbusy), int'(m_wl > 0 || m_wg > 0));
        chk("wrem", int'(wrem), m_wl);
        chk("err", int'(err), int'(m_err));
    endtask

    initial begin
        // Reset
        step();
        step();
        chk("rst_rreq", int'(rreq), 0);
        chk("rst_rrem", int'(rrem), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;

        // Read burst of 4, level steps 3 -> 4
        rthr = 5'd4; ren = 1'b1; rlvl = 5'd3;
        step();
        step();
        chk("lvl3_noreq", int'(rreq), 0);
        rlvl = 5'd4;
        step();
        chk("rise", int'(rreq), 1);
        chk("rise_rem", int'(rrem), 4);
        rack = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            step();
            chk("countdown", int'(rrem), i);
        end
        chk("gap_req", int'(rreq), 0);
        chk("gap_busy", int'(rbusy), 1);
        rack = 1'b0;
        step();
        chk("idle_req", int'(rreq), 0);
        step();
        chk("reraise", int'(rreq), 1);
        ren = 1'b0;
        rack = 1'b1;
        repeat (4) step();
        rack = 1'b0;
        repeat (3) step();
        chk("no_rearm", int'(rreq), 0);

        // Stray ack and clear priority
        rack = 1'b1;
        step();
        chk("stray_err", int'(err), 1);
        rack = 1'b0;
        step();
        chk("err_sticky", int'(err), 1);
        clr = 1'b1;
        step();
        chk("err_clr", int'(err), 0);
        rack = 1'b1;
        step();
        chk("set_wins", int'(err), 1);
        rack = 1'b0;
        step();
        clr = 1'b0;

        // Single-beat write bursts with threshold 0
        wthr = 5'd0; wfree = 5'd1; wen = 1'b1;
        repeat (20) begin
            wack = (m_wl > 0);
            step();
        end
        wack = 1'b0;
        chk("single_err", int'(err), 0);
        wen = 1'b0;
        repeat (3) step();

        // Threshold 31 clamps to 16
        wthr = 5'd31; wfree = 5'd15; wen = 1'b1;
        repeat (3) step();
        chk("clamp_noreq", int'(wreq), 0);
        wfree = 5'd16;
        step();
        chk("clamp_rise", int'(wrem), 16);
        wen = 1'b0;
        repeat (18) begin
            wack = (m_wl > 0);
            step();
        end
        wack = 1'b0;
        repeat (2) step();

        // Read burst of 8, enable dropped after 2 acks
        rthr = 5'd8; rlvl = 5'd9; ren = 1'b1;
        step();
        repeat (10) begin
            rack = (m_rl > 0);
            if (m_rl == 6) ren = 1'b0;
            step();
        end
        rack = 1'b0;
        repeat (3) step();
        chk("drop_noreq", int'(rreq), 0);

        // Concurrent bursts 4 / 6, then reset mid-burst
        rthr = 5'd4; wthr = 5'd6; rlvl = 5'd8; wfree = 5'd8;
        ren = 1'b1; wen = 1'b1;
        step();
        repeat (5) begin
            rack = (m_rl > 0) && ($urandom_range(0, 1) == 1);
            wack = (m_wl > 0) && ($urandom_range(0, 1) == 1);
            step();
        end
        rack = 1'b0; wack = 1'b0;
        repeat (6) begin
            rack = (m_rl > 0);
            wack = (m_wl > 0);
            step();
        end
        rack = 1'b0; wack = 1'b0;
        step();
        rack = (m_rl > 0);
        step();
        rack = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_rreq", int'(rreq), 0);
        chk("mid_rst_wreq", int'(wreq), 0);
        chk("mid_rst_rrem", int'(rrem), 0);
        chk("mid_rst_wbusy", int'(wbusy), 0);
        rst = 1'b0;

        // Random traffic
        repeat (2000) begin
            ren   = ($urandom_range(0, 7) != 0);
            wen   = ($urandom_range(0, 7) != 0);
            rlvl  = LW'($urandom_range(0, 31));
            wfree = LW'($urandom_range(0, 31));
            rthr  = LW'($urandom_range(0, 20));
            wthr  = LW'($urandom_range(0, 20));
            rack  = (m_rl > 0) ? ($urandom_range(0, 3) != 0)
                               : ($urandom_range(0, 31) == 0);
            wack  = (m_wl > 0) ? ($urandom_range(0, 3) != 0)
                               : ($urandom_range(0, 31) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; rack = 1'b0; wack = 1'b0; clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/v_dreq_gen.md
# v_dreq_gen

Peripheral-side DMA request generator: converts one peripheral's RX FIFO fill level and TX FIFO free space into burst requests toward the DMA request mux, and counts the per-beat acknowledges returned through it. One instance per DMA-capable peripheral. Its `rreq_o`/`wreq_o` feed one bit of the mux request vectors, and its `rack_i`/`wack_i` come from the matching ack bits. Read and write directions are independent, identical state machines.

## Interface
- `FIFO_DEPTH`, 16, peripheral FIFO depth in entries; `LW = $clog2(FIFO_DEPTH+1)`.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `ren_i` / `wen_i`  in  1 each  direction enable.
- `rlvl_i`  in  LW  RX FIFO entries available for the DMA to read.
- `wfree_i`  in  LW  TX FIFO entries free for the DMA to write.
- `rthr_i` / `wthr_i`  in  LW each  burst length in beats; 0 is treated as 1; values above FIFO_DEPTH are clamped to FIFO_DEPTH.
- `rreq_o` / `wreq_o`  out  1 each  request level toward the mux.
- `rack_i` / `wack_i`  in  1 each  one-cycle pulse per completed beat.
- `rbusy_o` / `wbusy_o`  out  1 each  direction FSM is not in IDLE.
- `rrem_o` / `wrem_o`  out  LW each  beats remaining in the current burst.
- `err_o`  out  1  sticky protocol error.
- `clr_err_i`  in  1  clears `err_o`.

## Operation
- Per-direction FSM (shown for read; write is identical, using `wfree_i`, `wthr_i`, `wack_i`):
  - IDLE: if `ren_i && rlvl_i >= thr_eff`, go to REQ and load `rrem = thr_eff`.
  - REQ: on each `rack_i`, decrement `rrem`. If `rack_i` arrives while `rrem == 1`, go to GAP.
  - GAP: one cycle, then go to IDLE.
- `thr_eff = max(1, min(thr, FIFO_DEPTH))`, computed in LW bits. The threshold and level are sampled only in IDLE; changes during REQ have no effect on the current burst.
- `rreq_o` is 1 exactly while the state is REQ (registered output). `rbusy_o` is 1 in REQ and GAP.
- Deasserting an enable during REQ does not abort the burst; the burst completes. The enable is rechecked in IDLE.
- A burst is never aborted except by reset.
- `rrem_o` shows the counter value. It is 0 in IDLE and GAP, and never decrements below 0.
- Error: `err_o` is set when an ack arrives in IDLE or GAP for its direction. Such an ack is otherwise ignored. If set and `clr_err_i` occur in the same cycle, set wins.
- Read and write run fully concurrently; simultaneous `rack_i` and `wack_i` are both honoured.

## Timing
- Reset values: `rreq_o = wreq_o = 0`, `rbusy_o = wbusy_o = 0`, `rrem_o = wrem_o = 0`, `err_o = 0`, both FSMs in IDLE.
- Reset mid-burst: on the next edge all outputs return to their reset values; the outstanding beats are discarded.
- Request latency: condition true in IDLE at edge t → `rreq_o = 1` after edge t.
- Ack latency: `rack_i` sampled at edge t → `rrem_o` decremented after edge t.
- Final ack sampled at edge t:
  - `rreq_o = 0` after edge t (GAP).
  - IDLE after edge t+1.
  - Earliest re-raise after edge t+2.
  - Request is therefore low for at least 2 cycles between bursts.
- Ack in the same cycle as the IDLE→REQ transition is not possible, because the request is not yet visible; an ack in that cycle sets `err_o`.
- Back-to-back acks, one per cycle, are supported: a burst of N beats keeps `rreq_o` high for N cycles minimum.

## Test plan
- Reset; `FIFO_DEPTH = 16`; `rthr_i = 4`; `rlvl_i` steps 3→4 with `ren_i = 1` → `rreq_o` rises one cycle after the level reaches 4, `rrem_o = 4`; acks on 4 consecutive cycles → `rrem_o` goes 3, 2, 1, 0, `rreq_o` low after the 4th ack, low for 2 cycles, re-raised if `rlvl_i` is still ≥ 4.
- `wthr_i = 0`, `wfree_i = 1`, `wen_i = 1` → single-beat bursts: one `wack_i` per request, `wreq_o` high ≥1 cycle and low ≥2 cycles between requests, `err_o` stays 0.
- `wthr_i = 31` → burst length clamped to 16: `wreq_o` rises only when `wfree_i = 16`, and stays high for 16 acks.
- Read burst of 8 with `ren_i` dropped after 2 acks → `rreq_o` stays high until the 8th ack, then no new request.
- `rack_i` pulse in IDLE → `err_o = 1` and stays set; assert `clr_err_i` alone → `err_o = 0`; assert a stray ack and `clr_err_i` in the same cycle → `err_o = 1`.
- Concurrent read and write bursts (4 and 6 beats) with interleaved and simultaneous acks → independent `rrem_o`/`wrem_o` countdowns. Then assert `rst_i` mid-burst → all outputs 0 on the next edge.
